// File: rtl/red_pitaya_pwm_pkg.sv
// Shared definitions for the dithered PWM bank.
//   - Config word layout: base duty in [23:16], per-period dither mask in [15:0].
//   - Counter widths and terminal values for the period counter and the dither index.
//   - pwm_thr(): 9-bit threshold for one channel in the current dither period.
package red_pitaya_pwm_pkg;

  localparam int unsigned CCW      = 24;
  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned DITH_LEN = CCW - PWM_BITS;
  localparam int unsigned IDX_BITS = 4;

  localparam int unsigned DUTY_MSB = CCW - 1;
  localparam int unsigned DUTY_LSB = DITH_LEN;
  localparam int unsigned MASK_MSB = DITH_LEN - 1;
  localparam int unsigned MASK_LSB = 0;

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [IDX_BITS-1:0] IDX_MAX = '1;

  typedef logic [CCW-1:0]      cfg_t;
  typedef logic [PWM_BITS:0]   thr_t;
  typedef logic [PWM_BITS-1:0] cnt_t;
  typedef logic [IDX_BITS-1:0] idx_t;

  // Threshold = duty + mask[idx]; the extra MSB holds the 256 case (duty 255 plus a dither bit).
  function automatic thr_t pwm_thr(input cfg_t cfg, input idx_t idx);
    logic [DITH_LEN-1:0] mask;
    thr_t                duty;
    thr_t                dith;
    mask = cfg[MASK_MSB:MASK_LSB];
    duty = {1'b0, cfg[DUTY_MSB:DUTY_LSB]};
    dith = {{PWM_BITS{1'b0}}, mask[idx]};
    return duty + dith;
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_ch.sv
// One dithered PWM channel.
//   clk_i   PWM clock
//   rst_i   synchronous active-high reset
//   load_i  capture cfg_i into the channel's config register (frame end or sync)
//   cnt_i   shared period counter
//   idx_i   shared dither index (period number within the frame)
//   cfg_i   live config word for this channel
//   pwm_o   registered PWM output
module red_pitaya_pwm_ch
  import red_pitaya_pwm_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [IDX_BITS-1:0] idx_i,
  input  logic [CCW-1:0]      cfg_i,
  output logic                pwm_o
);

  logic [CCW-1:0]  r_cfg;
  logic            r_pwm;
  logic [PWM_BITS:0] w_thr;
  logic            w_pwm_d;

  // The compare uses the config held for the current frame; a load on this edge only
  // affects the next counter value, so duty and mask always switch together.
  always_comb begin
    w_thr   = pwm_thr(r_cfg, idx_i);
    w_pwm_d = ({1'b0, cnt_i} < w_thr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (load_i) begin
        r_cfg <= cfg_i;
      end
      r_pwm <= w_pwm_d;
    end
  end

  assign pwm_o = r_pwm;

endmodule

// File: rtl/red_pitaya_pwm_bank.sv
// Multi-channel dithered PWM generator driving the slow-analog RC filters.
// Each channel produces base duty (out of 256) plus one extra high clock in the periods
// selected by its 16-bit dither mask; a frame is 16 periods.
//   clk_i    PWM clock
//   rst_i    synchronous active-high reset
//   cfg_i    NCH packed config words, channel n at [n*CCW +: CCW]
//   sync_i   frame restart; counters return to zero and config loads immediately
//   pwm_o    registered PWM outputs, bit n = channel n
//   frame_o  registered strobe on the first clock of each frame seen on pwm_o
module red_pitaya_pwm_bank
  import red_pitaya_pwm_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NCH*CCW-1:0] cfg_i,
  input  logic               sync_i,
  output logic [NCH-1:0]     pwm_o,
  output logic               frame_o
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [IDX_BITS-1:0] r_idx;
  logic                r_frame;
  logic                w_period_end;
  logic                w_frame_end;
  logic                w_frame_start;
  logic                w_load;

  always_comb begin
    w_period_end  = (r_cnt == CNT_MAX);
    w_frame_end   = w_period_end && (r_idx == IDX_MAX);
    w_frame_start = (r_cnt == '0) && (r_idx == '0);
    // A sync on the frame-end edge is a single load, same as either alone.
    w_load        = w_frame_end || sync_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
    end else begin
      if (sync_i) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (w_period_end) begin
          r_idx <= r_idx + 1'b1;
        end
      end
      // Registered from the same counter value the channels compare, so it lines up with pwm_o.
      r_frame <= w_frame_start;
    end
  end

  assign frame_o = r_frame;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    red_pitaya_pwm_ch u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (w_load),
      .cnt_i  (r_cnt),
      .idx_i  (r_idx),
      .cfg_i  (cfg_i[n*CCW +: CCW]),
      .pwm_o  (pwm_o[n])
    );
  end

endmodule

// File: tb/tb_red_pitaya_pwm_bank.sv
// Self-checking bench for red_pitaya_pwm_bank: cycle-level scoreboard plus frame statistics.
module tb_red_pitaya_pwm_bank;

  localparam int NCH = 4;
  localparam int CW  = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic               sync;
  logic [NCH*CW-1:0]  cfg_drv;
  logic [NCH-1:0]     pwm;
  logic               frame;

  always #5 clk = ~clk;

  red_pitaya_pwm_bank #(
    .NCH (NCH)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cfg_i   (cfg_drv),
    .sync_i  (sync),
    .pwm_o   (pwm),
    .frame_o (frame)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard: reference model pushes what each edge should produce
  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           frame;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  m_cnt;
  logic [3:0]  m_idx;
  logic [23:0] m_cfg [NCH];

  always @(posedge clk) begin : model
    exp_t       e;
    logic [8:0] thr;
    logic       ld;
    e = '0;
    if (rst) begin
      m_cnt <= 8'd0;
      m_idx <= 4'd0;
      for (int n = 0; n < NCH; n++) m_cfg[n] <= 24'd0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        thr = {1'b0, m_cfg[n][23:16]} + {8'd0, m_cfg[n][m_idx]};
        e.pwm[n] = ({1'b0, m_cnt} < thr);
      end
      e.frame = (m_cnt == 8'd0) && (m_idx == 4'd0);
      ld = sync || ((m_cnt == 8'hFF) && (m_idx == 4'hF));
      if (sync) begin
        m_cnt <= 8'd0;
        m_idx <= 4'd0;
      end else begin
        m_cnt <= m_cnt + 8'd1;
        if (m_cnt == 8'hFF) m_idx <= m_idx + 4'd1;
      end
      if (ld) for (int n = 0; n < NCH; n++) m_cfg[n] <= cfg_drv[n*CW +: CW];
    end
    sb_q.push_back(e);
  end

  // Advance to the next falling edge and compare the output the last rising edge produced.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sb_q.pop_front();
      if ({pwm, frame} !== e) begin
        n_errors++;
        $display("FAIL scoreboard t=%0t actual pwm=%b frame=%b expected pwm=%b frame=%b",
                 $time, pwm, frame, e.pwm, e.frame);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- frame statistics
  int   hi_cnt [NCH];
  int   p_cnt  [NCH][16];
  int   n_frames;
  logic first_frame;

  task automatic start_frame(input logic [NCH*CW-1:0] c);
    cfg_drv = c;
    sync    = 1'b1;
    tick();
    sync    = 1'b0;
    tick();  // now looking at sample 0 of the restarted frame
  endtask

  // Collect one frame of 4096 samples; optionally change cfg_i right after sample chg_at.
  task automatic count_frame(input bit use_current, input int chg_at,
                             input logic [NCH*CW-1:0] chg_cfg);
    n_frames    = 0;
    first_frame = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      hi_cnt[n] = 0;
      for (int p = 0; p < 16; p++) p_cnt[n][p] = 0;
    end
    for (int k = 0; k < 4096; k++) begin
      if (k != 0 || !use_current) tick();
      for (int n = 0; n < NCH; n++) begin
        if (pwm[n]) begin
          hi_cnt[n]++;
          p_cnt[n][k/256]++;
        end
      end
      if (frame) n_frames++;
      if (k == 0) first_frame = frame;
      if (k == chg_at) cfg_drv = chg_cfg;
    end
  endtask

  // ---------------- table of whole-frame vectors
  typedef struct packed {
    logic [NCH*CW-1:0]    cfg;
    logic [NCH-1:0][12:0] hi;
    logic [NCH-1:0][12:0] p0;
    logic [NCH-1:0][12:0] p1;
  } vec_t;

  vec_t vecs [3];

  initial begin
    vecs[0].cfg = {4{24'h80_0000}};
    vecs[0].hi  = {4{13'd2048}};
    vecs[0].p0  = {4{13'd128}};
    vecs[0].p1  = {4{13'd128}};

    vecs[1].cfg = {4{24'h80_5555}};
    vecs[1].hi  = {4{13'd2056}};
    vecs[1].p0  = {4{13'd129}};
    vecs[1].p1  = {4{13'd128}};

    // ch0 full on, ch1 off, ch2 255/256, ch3 duty 1 with odd-period dither
    vecs[2].cfg = {24'h01_AAAA, 24'hFF_0000, 24'h00_0000, 24'hFF_FFFF};
    vecs[2].hi  = {13'd24, 13'd4080, 13'd0, 13'd4096};
    vecs[2].p0  = {13'd1,  13'd255,  13'd0, 13'd256};
    vecs[2].p1  = {13'd2,  13'd255,  13'd0, 13'd256};

    rst     = 1'b1;
    sync    = 1'b0;
    cfg_drv = '0;
    @(posedge clk);
    repeat (3) tick();
    check("reset_pwm", int'(pwm), 0);
    check("reset_frame", int'(frame), 0);
    rst = 1'b0;

    // Table: steady-state frames after a sync restart
    for (int v = 0; v < 3; v++) begin
      start_frame(vecs[v].cfg);
      count_frame(1'b1, -1, '0);
      check($sformatf("vec%0d_frame_first", v), int'(first_frame), 1);
      check($sformatf("vec%0d_frame_count", v), n_frames, 1);
      for (int n = 0; n < NCH; n++) begin
        check($sformatf("vec%0d_ch%0d_frame_high", v, n), hi_cnt[n], int'(vecs[v].hi[n]));
        check($sformatf("vec%0d_ch%0d_period0_high", v, n), p_cnt[n][0], int'(vecs[v].p0[n]));
        check($sformatf("vec%0d_ch%0d_period1_high", v, n), p_cnt[n][1], int'(vecs[v].p1[n]));
      end
    end

    // Mid-frame cfg change is held off until the frame boundary
    start_frame({4{24'h40_0000}});
    count_frame(1'b1, 7*256 + 10, {4{24'hC0_0000}});
    for (int n = 0; n < NCH; n++) check($sformatf("hold_old_ch%0d", n), hi_cnt[n], 1024);
    count_frame(1'b0, -1, '0);
    check("hold_new_frame_first", int'(first_frame), 1);
    for (int n = 0; n < NCH; n++) check($sformatf("hold_new_ch%0d", n), hi_cnt[n], 3072);

    // Sync at cnt=100, idx=5: restart with new config, frame_o one clock later
    start_frame({4{24'h20_0000}});
    repeat (5*256 + 100 - 1) tick();
    cfg_drv = {4{24'hE0_0000}};
    sync    = 1'b1;
    tick();
    check("sync_no_frame_yet", int'(frame), 0);
    sync = 1'b0;
    tick();
    check("sync_frame_strobe", int'(frame), 1);
    count_frame(1'b1, -1, '0);
    check("sync_frame_count", n_frames, 1);
    check("sync_new_period0", p_cnt[0][0], 224);
    check("sync_new_frame_high", hi_cnt[3], 3584);

    // Sync held high: live config with one clock of latency
    cfg_drv = '0;
    sync    = 1'b1;
    repeat (3) tick();
    check("sync_hold_low", int'(pwm), 0);
    cfg_drv = {4{24'hFF_0000}};
    repeat (2) tick();
    check("sync_hold_live_pwm", int'(pwm), 15);
    check("sync_hold_frame", int'(frame), 1);
    sync = 1'b0;

    // Reset mid-period while high, then one all-low frame
    start_frame({4{24'h80_0000}});
    repeat (49) tick();
    check("rst_pre_high", int'(pwm), 15);
    rst = 1'b1;
    tick();
    check("rst_pwm_low", int'(pwm), 0);
    check("rst_frame_low", int'(frame), 0);
    repeat (2) tick();
    rst = 1'b0;
    count_frame(1'b0, -1, '0);
    check("post_rst_frame_first", int'(first_frame), 1);
    for (int n = 0; n < NCH; n++) check($sformatf("post_rst_low_ch%0d", n), hi_cnt[n], 0);
    tick();
    check("post_rst_loaded", int'(pwm), 15);
    check("post_rst_frame2", int'(frame), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
